// File: rtl/dac_serial_ctrl.sv
// Switch sequencer for a two-capacitor serial charge-redistribution DAC.
// Clears C2, then per bit (LSB first) charges or dumps C1 and shares it onto C2.
module dac_serial_ctrl #(
  parameter int Bits = 6,
  parameter int Dead = 1
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Start,
  input  logic [Bits-1:0] Data,
  output logic            Clear,
  output logic            Charge,
  output logic            Dump,
  output logic            Share,
  output logic            Busy,
  output logic            Done,
  output logic [Bits-1:0] Code
);

  localparam int            CW       = $clog2(Bits + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(Bits);
  localparam logic [CW-1:0] CNT_LAST = CW'(1);
  localparam bit            HAS_GAP  = (Dead > 0);
  localparam logic [1:0]    GAP_LAST = (Dead > 0) ? 2'(Dead - 1) : 2'd0;

  typedef enum logic [2:0] {IDLE, CLR, SET, SHR, GAP} state_t;

  state_t          state_q, state_d;
  state_t          pend_q, pend_d;
  logic [Bits-1:0] shift_q, shift_d;
  logic [Bits-1:0] code_q, code_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      gap_q, gap_d;
  logic            clear_q, clear_d;
  logic            charge_q, charge_d;
  logic            dump_q, dump_d;
  logic            share_q, share_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    shift_d = shift_q;
    code_d  = code_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    done_d  = done_q;

    case (state_q)
      IDLE: begin
        if (Start) begin
          code_d  = Data;
          shift_d = Data;
          cnt_d   = CNT_INIT;
          done_d  = 1'b0;
          state_d = CLR;
        end
      end
      CLR: begin
        if (HAS_GAP) begin
          state_d = GAP;
          pend_d  = SET;
          gap_d   = 2'd0;
        end else begin
          state_d = SET;
        end
      end
      SET: begin
        if (HAS_GAP) begin
          state_d = GAP;
          pend_d  = SHR;
          gap_d   = 2'd0;
        end else begin
          state_d = SHR;
        end
      end
      SHR: begin
        shift_d = shift_q >> 1;
        cnt_d   = cnt_q - CW'(1);
        if (cnt_q == CNT_LAST) begin
          // The final share leaves the analog output settled; no trailing gap.
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (HAS_GAP) begin
          state_d = GAP;
          pend_d  = SET;
          gap_d   = 2'd0;
        end else begin
          state_d = SET;
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = pend_q;
        end else begin
          gap_d = gap_q + 2'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Switch controls are a registered image of the state being entered, so
    // at most one switch can be closed in any cycle.
    clear_d  = (state_d == CLR);
    charge_d = (state_d == SET) &&  shift_d[0];
    dump_d   = (state_d == SET) && !shift_d[0];
    share_d  = (state_d == SHR);
    busy_d   = (state_d != IDLE);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= IDLE;
      pend_q   <= SET;
      shift_q  <= '0;
      code_q   <= '0;
      cnt_q    <= '0;
      gap_q    <= 2'd0;
      clear_q  <= 1'b0;
      charge_q <= 1'b0;
      dump_q   <= 1'b0;
      share_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      shift_q  <= shift_d;
      code_q   <= code_d;
      cnt_q    <= cnt_d;
      gap_q    <= gap_d;
      clear_q  <= clear_d;
      charge_q <= charge_d;
      dump_q   <= dump_d;
      share_q  <= share_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign Clear  = clear_q;
  assign Charge = charge_q;
  assign Dump   = dump_q;
  assign Share  = share_q;
  assign Busy   = busy_q;
  assign Done   = done_q;
  assign Code   = code_q;

endmodule

// File: tb/tb_dac_serial_ctrl.sv
// Bench for dac_serial_ctrl: three configurations checked cycle by cycle
// against a phase-list model built from the conversion rules.
module tb_dac_serial_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [2:0] start;
  logic [5:0] data0, data1;
  logic [1:0] data2;
  logic [2:0] clr, chg, dmp, shr, bsy, dn;
  logic [5:0] code0, code1;
  logic [1:0] code2;

  dac_serial_ctrl #(.Bits(6), .Dead(0)) u_d0 (
    .Clk(clk), .Reset(rst), .Start(start[0]), .Data(data0),
    .Clear(clr[0]), .Charge(chg[0]), .Dump(dmp[0]), .Share(shr[0]),
    .Busy(bsy[0]), .Done(dn[0]), .Code(code0));

  dac_serial_ctrl #(.Bits(6), .Dead(1)) u_d1 (
    .Clk(clk), .Reset(rst), .Start(start[1]), .Data(data1),
    .Clear(clr[1]), .Charge(chg[1]), .Dump(dmp[1]), .Share(shr[1]),
    .Busy(bsy[1]), .Done(dn[1]), .Code(code1));

  dac_serial_ctrl #(.Bits(2), .Dead(3)) u_d2 (
    .Clk(clk), .Reset(rst), .Start(start[2]), .Data(data2),
    .Clear(clr[2]), .Charge(chg[2]), .Dump(dmp[2]), .Share(shr[2]),
    .Busy(bsy[2]), .Done(dn[2]), .Code(code2));

  int bits_t[3] = '{6, 6, 2};
  int dead_t[3] = '{0, 1, 3};

  int total = 0;
  int bad   = 0;

  // Expected {Clear,Charge,Dump,Share,Busy,Done} and Code seen at a negedge,
  // plus the Start/Data applied right after that sample.
  typedef struct {
    logic [5:0]  w;
    logic [15:0] code;
    logic        start;
    logic [15:0] data;
  } step_t;
  step_t seq[$];

  typedef struct {
    int          sel;
    logic [15:0] data;
    int          exp_busy;
    int          exp_charge;
    int          exp_dump;
  } vec_t;
  vec_t vecs[6];

  function automatic logic [15:0] mask_of(input int sel);
    return (bits_t[sel] == 6) ? 16'h003F : 16'h0003;
  endfunction

  function automatic logic [5:0] outs(input int sel);
    return {clr[sel], chg[sel], dmp[sel], shr[sel], bsy[sel], dn[sel]};
  endfunction

  function automatic logic [15:0] code_of(input int sel);
    case (sel)
      0:       return {10'd0, code0};
      1:       return {10'd0, code1};
      default: return {14'd0, code2};
    endcase
  endfunction

  task automatic drive(input int sel, input logic s, input logic [15:0] d);
    start[sel] = s;
    case (sel)
      0:       data0 = d[5:0];
      1:       data1 = d[5:0];
      default: data2 = d[1:0];
    endcase
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void push(input logic [5:0] w, input logic [15:0] c, input logic st);
    seq.push_back('{w: w, code: c, start: st, data: c});
  endfunction

  // Model: Clear, then per bit LSB first: [gap] Charge/Dump [gap] Share.
  function automatic void add_conv(input int sel, input logic [15:0] d, input logic st);
    push(6'b100010, d, st);
    for (int i = 0; i < bits_t[sel]; i++) begin
      repeat (dead_t[sel]) push(6'b000010, d, st);
      push(d[i] ? 6'b010010 : 6'b001010, d, st);
      repeat (dead_t[sel]) push(6'b000010, d, st);
      push(6'b000110, d, st);
    end
  endfunction

  function automatic void add_done(input logic [15:0] d, input int n);
    for (int i = 0; i < n; i++) push(6'b000001, d, 1'b0);
  endfunction

  task automatic kick(input int sel, input logic [15:0] d);
    drive(sel, 1'b1, d);
    @(negedge clk);
  endtask

  task automatic run_seq(input int sel, input string tag,
                         output int busy_n, output int charge_n, output int dump_n);
    logic [5:0] o;
    busy_n = 0; charge_n = 0; dump_n = 0;
    for (int i = 0; i < seq.size(); i++) begin
      o = outs(sel);
      check($sformatf("%s[%0d].outs", tag, i), {10'd0, o}, {10'd0, seq[i].w});
      check($sformatf("%s[%0d].code", tag, i), code_of(sel), seq[i].code);
      check($sformatf("%s[%0d].onehot", tag, i), 16'($countones(o[5:2]) <= 1), 16'd1);
      busy_n   += int'(o[1]);
      charge_n += int'(o[4]);
      dump_n   += int'(o[3]);
      drive(sel, seq[i].start, seq[i].data);
      @(negedge clk);
    end
  endtask

  task automatic check_reset_state(input string tag);
    for (int s = 0; s < 3; s++) begin
      check($sformatf("%s.outs%0d", tag, s), {10'd0, outs(s)}, 16'd0);
      check($sformatf("%s.code%0d", tag, s), code_of(s), 16'd0);
    end
  endtask

  initial begin
    int bn, cn, dnn;
    logic [15:0] rd;
    int rs;

    vecs[0] = '{sel: 0, data: 16'h002D, exp_busy: 13, exp_charge: 4, exp_dump: 2};
    vecs[1] = '{sel: 1, data: 16'h003F, exp_busy: 25, exp_charge: 6, exp_dump: 0};
    vecs[2] = '{sel: 2, data: 16'h0002, exp_busy: 17, exp_charge: 1, exp_dump: 1};
    vecs[3] = '{sel: 0, data: 16'h0000, exp_busy: 13, exp_charge: 0, exp_dump: 6};
    vecs[4] = '{sel: 1, data: 16'h0000, exp_busy: 25, exp_charge: 0, exp_dump: 6};
    vecs[5] = '{sel: 2, data: 16'h0003, exp_busy: 17, exp_charge: 2, exp_dump: 0};

    rst = 1'b1; start = 3'b000; data0 = '0; data1 = '0; data2 = '0;
    repeat (2) @(negedge clk);
    check_reset_state("reset");
    rst = 1'b0;
    @(negedge clk);

    foreach (vecs[v]) begin
      seq.delete();
      add_conv(vecs[v].sel, vecs[v].data, 1'b0);
      add_done(vecs[v].data, 2);
      kick(vecs[v].sel, vecs[v].data);
      run_seq(vecs[v].sel, $sformatf("vec%0d", v), bn, cn, dnn);
      check($sformatf("vec%0d.busy_cycles", v), 16'(bn), 16'(vecs[v].exp_busy));
      check($sformatf("vec%0d.charges", v), 16'(cn), 16'(vecs[v].exp_charge));
      check($sformatf("vec%0d.dumps", v), 16'(dnn), 16'(vecs[v].exp_dump));
      $display("vec%0d sel=%0d data=%h busy=%0d charge=%0d dump=%0d", v,
               vecs[v].sel, vecs[v].data, bn, cn, dnn);
    end

    // Start re-pulsed and Data zeroed mid-conversion: must be ignored.
    seq.delete();
    add_conv(0, 16'h002D, 1'b0);
    add_done(16'h002D, 3);
    seq[3].start = 1'b1;
    for (int i = 3; i < seq.size(); i++) seq[i].data = 16'h0000;
    kick(0, 16'h002D);
    run_seq(0, "midstart", bn, cn, dnn);
    check("midstart.busy_cycles", 16'(bn), 16'd13);
    $display("midstart busy=%0d charge=%0d dump=%0d", bn, cn, dnn);

    // Start held: Done lasts one cycle, next Clear lands as Done falls.
    seq.delete();
    add_conv(0, 16'h0000, 1'b1);
    seq.push_back('{w: 6'b000001, code: 16'h0000, start: 1'b1, data: 16'h002A});
    add_conv(0, 16'h002A, 1'b0);
    add_done(16'h002A, 1);
    kick(0, 16'h0000);
    run_seq(0, "held", bn, cn, dnn);
    check("held.dumps", 16'(dnn), 16'd9);
    $display("held busy=%0d charge=%0d dump=%0d", bn, cn, dnn);

    // Reset together with Start.
    rst = 1'b1;
    drive(0, 1'b1, 16'h0015);
    @(negedge clk);
    check_reset_state("rst_start");
    rst = 1'b0;
    drive(0, 1'b0, 16'h0015);
    @(negedge clk);
    check("rst_start.idle", {10'd0, outs(0)}, 16'd0);
    $display("rst_start outs=%b code=%h", outs(0), code_of(0));

    // Reset at cycle 5 of a conversion, then a full fresh conversion.
    kick(0, 16'h002D);
    drive(0, 1'b0, 16'h002D);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_state("rst_mid");
    rst = 1'b0;
    @(negedge clk);
    seq.delete();
    add_conv(0, 16'h0019, 1'b0);
    add_done(16'h0019, 1);
    kick(0, 16'h0019);
    run_seq(0, "post_rst", bn, cn, dnn);
    check("post_rst.busy_cycles", 16'(bn), 16'd13);
    $display("post_rst busy=%0d charge=%0d dump=%0d", bn, cn, dnn);

    // Random codes with Start/Data noise while busy.
    for (int r = 0; r < 24; r++) begin
      rs = int'($urandom_range(0, 2));
      rd = 16'($urandom) & mask_of(rs);
      seq.delete();
      add_conv(rs, rd, 1'b0);
      for (int i = 1; i < seq.size(); i++) begin
        seq[i].start = 1'($urandom);
        seq[i].data  = 16'($urandom) & mask_of(rs);
      end
      add_done(rd, 1);
      kick(rs, rd);
      run_seq(rs, $sformatf("rand%0d", r), bn, cn, dnn);
      check($sformatf("rand%0d.busy_cycles", r), 16'(bn),
            16'(1 + 2 * bits_t[rs] + dead_t[rs] * 2 * bits_t[rs]));
      $display("rand%0d sel=%0d data=%h busy=%0d", r, rs, rd, bn);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
